// File: rtl/uart_rx_typed_dechunker_pkg.sv
// Shared definitions for the typed-chunk UART receive path:
// decoder states and the header/escape byte.
package uart_rx_typed_dechunker_pkg;

    localparam int unsigned STATE_W  = 2;
    localparam logic [7:0]  HDR_BYTE = 8'h00;

    typedef enum logic [STATE_W-1:0] {
        ST_SYNC,
        ST_HDR,
        ST_DATA,
        ST_ESC
    } state_t;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Saturating idle counter: cleared by each received byte; expired holds high
// once TIMEOUT_CYCLES idle cycles have elapsed. TIMEOUT_CYCLES=0 disables it.
module uart_rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/uart_rx_typed_dechunker.sv
// Strips 0x00+type chunk headers from a received byte stream, un-escapes
// 0x00 0x00 into a data 0x00, and emits each completed chunk as a packed buffer.
module uart_rx_typed_dechunker
    import uart_rx_typed_dechunker_pkg::*;
#(
    parameter int unsigned BUFFER_BYTE_SIZE  = 3,
    parameter int unsigned BUFFER_INDEX_SIZE = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          is_rx_done,
    input  logic [7:0]                    rx_data,
    output logic                          is_chunk_ready,
    output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
    output logic [7:0]                    chunk_type,
    output logic                          is_frame_error
);

    state_t                          state, state_nxt;
    logic [BUFFER_BYTE_SIZE*8-1:0]   work_bytes, work_nxt;
    logic [BUFFER_INDEX_SIZE-1:0]    wr_index, idx_nxt;
    logic [7:0]                      pending_type;
    logic                            store, emit_req, emit, load_type, frame_err_nxt;
    logic                            expired;

    uart_rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (is_rx_done),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        store         = 1'b0;
        emit_req      = 1'b0;
        load_type     = 1'b0;
        frame_err_nxt = 1'b0;
        work_nxt      = work_bytes;
        idx_nxt       = wr_index;
        case (state)
            ST_SYNC: begin
                if (is_rx_done) begin
                    if (rx_data == HDR_BYTE) state_nxt = ST_HDR;
                    else                     frame_err_nxt = 1'b1;
                end
            end
            ST_HDR: begin
                if (is_rx_done && rx_data != HDR_BYTE) begin
                    load_type = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (is_rx_done) begin
                    if (rx_data == HDR_BYTE) state_nxt = ST_ESC;
                    else                     store = 1'b1;
                end else if (expired) begin
                    emit_req  = 1'b1;
                    state_nxt = ST_SYNC;
                end
            end
            ST_ESC: begin
                if (is_rx_done) begin
                    if (rx_data == HDR_BYTE) begin
                        store     = 1'b1;
                        state_nxt = ST_DATA;
                    end else begin
                        emit_req  = 1'b1;
                        load_type = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end else if (expired) begin
                    // the unpaired 0x00 opens the next header
                    emit_req  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase

        if (store) begin
            for (int unsigned i = 0; i < BUFFER_BYTE_SIZE; i++) begin
                if (wr_index == BUFFER_INDEX_SIZE'(i)) work_nxt[i*8 +: 8] = rx_data;
            end
            idx_nxt = wr_index + 1'b1;
            if (idx_nxt == BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE)) begin
                emit_req  = 1'b1;
                state_nxt = ST_SYNC;
            end
        end

        emit = emit_req && (idx_nxt != '0);
    end

    // Emit copies the post-store view so a full-buffer store lands in the chunk.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work_bytes      <= '0;
            wr_index        <= '0;
            pending_type    <= '0;
            is_chunk_ready  <= 1'b0;
            is_frame_error  <= 1'b0;
            chunk_bytes     <= '0;
            chunk_byte_size <= '0;
            chunk_type      <= '0;
        end else begin
            is_chunk_ready <= emit;
            is_frame_error <= frame_err_nxt;
            if (emit) begin
                chunk_bytes     <= work_nxt;
                chunk_byte_size <= idx_nxt;
                chunk_type      <= pending_type;
            end
            if (emit || load_type) begin
                work_bytes <= '0;
                wr_index   <= '0;
            end else begin
                work_bytes <= work_nxt;
                wr_index   <= idx_nxt;
            end
            if (load_type) pending_type <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_typed_dechunker.sv
// Scoreboard bench for uart_rx_typed_dechunker: directed byte streams push
// hand-computed chunks; a monitor pops and compares on each is_chunk_ready.
module tb_uart_rx_typed_dechunker;

    localparam int unsigned TO = 20;

    logic        CLK = 1'b0;
    logic        RST;
    logic        is_rx_done;
    logic [7:0]  rx_data;
    logic        is_chunk_ready;
    logic [23:0] chunk_bytes;
    logic [31:0] chunk_byte_size;
    logic [7:0]  chunk_type;
    logic        is_frame_error;

    uart_rx_typed_dechunker #(
        .BUFFER_BYTE_SIZE  (3),
        .BUFFER_INDEX_SIZE (32),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .is_rx_done      (is_rx_done),
        .rx_data         (rx_data),
        .is_chunk_ready  (is_chunk_ready),
        .chunk_bytes     (chunk_bytes),
        .chunk_byte_size (chunk_byte_size),
        .chunk_type      (chunk_type),
        .is_frame_error  (is_frame_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] b;
        logic [31:0] sz;
        logic [7:0]  ty;
    } chunk_t;

    chunk_t exp_q[$];
    chunk_t e;
    int vectors     = 0;
    int miscompares = 0;
    int fe_seen     = 0;
    int fe_exp      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (is_frame_error) fe_seen++;
            if (is_chunk_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_chunk: got type %h size %0d bytes %h, want none",
                             chunk_type, chunk_byte_size, chunk_bytes);
                end else begin
                    e = exp_q.pop_front();
                    check("chunk_bytes", {8'h00, chunk_bytes}, {8'h00, e.b});
                    check("chunk_byte_size", chunk_byte_size, e.sz);
                    check("chunk_type", {24'h0, chunk_type}, {24'h0, e.ty});
                end
            end
        end
    end

    task automatic expect_chunk(input logic [23:0] b, input logic [31:0] sz, input logic [7:0] ty);
        chunk_t c;
        c.b  = b;
        c.sz = sz;
        c.ty = ty;
        exp_q.push_back(c);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        is_rx_done = 1'b1;
        rx_data    = b;
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        is_rx_done = 1'b0;
        rx_data    = 8'h00;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, is_chunk_ready}, 32'h0);
        check({tag, "_ferr"}, {31'h0, is_frame_error}, 32'h0);
        check({tag, "_bytes"}, {8'h00, chunk_bytes}, 32'h0);
        check({tag, "_size"}, chunk_byte_size, 32'h0);
        check({tag, "_type"}, {24'h0, chunk_type}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        is_rx_done = 1'b0;
        rx_data    = 8'h00;
        repeat (3) @(negedge CLK);
        check_zero_outputs("reset");
        RST = 1'b0;
        idle(2);

        // full buffer closes the chunk
        expect_chunk(24'h434241, 3, 8'h05);
        send(8'h00); send(8'h05); send(8'h41); send(8'h42); send(8'h43);
        idle(5);

        // escaped null then timeout in DATA
        expect_chunk(24'h004100, 2, 8'h07);
        send(8'h00); send(8'h07); send(8'h00); send(8'h00); send(8'h41);
        idle(TO + 5);

        // header inside a chunk, then a full second chunk
        expect_chunk(24'h000011, 1, 8'h03);
        expect_chunk(24'h443322, 3, 8'h09);
        send(8'h00); send(8'h03); send(8'h11); send(8'h00);
        send(8'h09); send(8'h22); send(8'h33); send(8'h44);
        idle(5);

        // out-of-sync byte, null run in HDR, timeout
        fe_exp++;
        expect_chunk(24'h000055, 1, 8'h02);
        send(8'h41); send(8'h00); send(8'h00); send(8'h02); send(8'h55);
        idle(TO + 5);

        // timeout in ESC leaves the block in HDR
        expect_chunk(24'h0000AA, 1, 8'h04);
        send(8'h00); send(8'h04); send(8'hAA); send(8'h00);
        idle(TO + 5);
        expect_chunk(24'h0000BB, 1, 8'h06);
        send(8'h06); send(8'hBB);
        idle(TO + 5);

        // empty chunk on timeout: nothing emitted
        send(8'h00); send(8'h08);
        idle(TO + 5);

        // reset mid-chunk discards it and clears outputs
        send(8'h00); send(8'h04); send(8'hAA);
        idle(2);
        RST = 1'b1;
        @(negedge CLK);
        check_zero_outputs("midreset");
        RST = 1'b0;
        idle(2);

        expect_chunk(24'hC3C2C1, 3, 8'h01);
        send(8'h00); send(8'h01); send(8'hC1); send(8'hC2); send(8'hC3);
        idle(5);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        check("frame_errors", fe_seen, fe_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
